alu_muldiv: RTL and testbench



---
 rtl/alu_muldiv_pkg.sv | 40 ++++
 rtl/muldiv_seq.sv | 137 +++++++++++++
 rtl/alu_muldiv.sv | 79 +++++++
 tb/tb_alu_muldiv.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// ============================================================================
// Module  : alu_muldiv_pkg
// Brief   : Opcode encodings, FSM state constants and helpers for alu_muldiv.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_muldiv_pkg;

   localparam logic [3:0] c_op_and   = 4'b0000;
   localparam logic [3:0] c_op_or    = 4'b0001;
   localparam logic [3:0] c_op_add   = 4'b0010;
   localparam logic [3:0] c_op_xor   = 4'b0011;
   localparam logic [3:0] c_op_mult  = 4'b0100;
   localparam logic [3:0] c_op_multu = 4'b0101;
   localparam logic [3:0] c_op_sub   = 4'b0110;
   localparam logic [3:0] c_op_slt   = 4'b0111;
   localparam logic [3:0] c_op_sltu  = 4'b1000;
   localparam logic [3:0] c_op_mfhi  = 4'b1010;
   localparam logic [3:0] c_op_mflo  = 4'b1011;
   localparam logic [3:0] c_op_nor   = 4'b1100;
   localparam logic [3:0] c_op_div   = 4'b1101;
   localparam logic [3:0] c_op_divu  = 4'b1110;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_fix  = 2'd2;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == c_op_mult) || (op == c_op_multu) ||
             (op == c_op_div)  || (op == c_op_divu);
   endfunction

   function automatic logic is_signed_md(input logic [3:0] op);
      return (op == c_op_mult) || (op == c_op_div);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module  : muldiv_seq
// Brief   : Iterative shift-add multiplier / restoring divider owning HI/LO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_seq
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int                c_cw   = $clog2(WIDTH) + 1;
   localparam logic [c_cw-1:0]   c_last = c_cw'(WIDTH - 1);

   logic [1:0]         r_state;
   logic [c_cw-1:0]    r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mag_b;
   logic [WIDTH-1:0]   r_a_raw;
   logic [3:0]         r_op;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_b_zero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_sgn;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH-1:0]   w_diff;
   logic               w_ge;
   logic               w_is_div;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;

   assign w_sgn    = is_signed_md(op);
   assign w_mag_a  = (w_sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign w_mag_b  = (w_sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
   assign w_is_div = (r_op == c_op_div) || (r_op == c_op_divu);

   // Multiply: upper half accumulates the multiplicand, the pair shifts right
   assign w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mag_b : {WIDTH{1'b0}})};

   // Divide: partial remainder never exceeds the divisor, so W bits hold the difference
   assign w_trial  = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge     = w_trial >= {1'b0, r_mag_b};
   assign w_diff   = w_trial[WIDTH-1:0] - r_mag_b;

   assign w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_quot   = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
   assign w_rem    = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= c_st_idle;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mag_b  <= '0;
         r_a_raw  <= '0;
         r_op     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (start && is_muldiv(op)) begin
                  r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mag_b  <= w_mag_b;
                  r_a_raw  <= a;
                  r_op     <= op;
                  r_neg_q  <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_r  <= w_sgn && a[WIDTH-1];
                  r_b_zero <= (b == '0);
                  r_cnt    <= '0;
                  r_state  <= c_st_run;
               end
            end
            c_st_run: begin
               if (w_is_div) begin
                  r_acc <= w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                                : {r_acc[2*WIDTH-2:0], 1'b0};
               end else begin
                  r_acc <= {w_add, r_acc[WIDTH-1:1]};
               end
               r_cnt <= r_cnt + c_cw'(1);
               if (r_cnt == c_last) begin
                  r_state <= c_st_fix;
               end
            end
            c_st_fix: begin
               if (!w_is_div) begin
                  {r_hi, r_lo} <= w_prod;
               end else if (r_b_zero) begin
                  r_hi <= r_a_raw;
                  r_lo <= {WIDTH{1'b1}};
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end
               r_done  <= 1'b1;
               r_state <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign busy = (r_state != c_st_idle);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
// Module  : alu_muldiv
// Brief   : Execute-stage ALU: combinational op mux plus multi-cycle mul/div.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_dif;
   logic             w_slt;

   assign w_sum = a + b;
   assign w_dif = a - b;
   assign w_slt = $signed(a) < $signed(b);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alu_control)
         c_op_add: begin
            result   = w_sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         c_op_sub: begin
            result   = w_dif;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
         end
         c_op_and:  result = a & b;
         c_op_or:   result = a | b;
         c_op_xor:  result = a ^ b;
         c_op_nor:  result = ~(a | b);
         c_op_slt:  result = {{(WIDTH-1){1'b0}}, w_slt};
         c_op_sltu: result = {{(WIDTH-1){1'b0}}, (a < b)};
         c_op_mfhi: result = hi;
         c_op_mflo: result = lo;
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

   muldiv_seq #(
      .WIDTH (WIDTH)
   ) u_seq (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (alu_control),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
// Module  : tb_alu_muldiv
// Brief   : Self-checking bench for alu_muldiv against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] a, b;
   logic [3:0]  alu_control;
   logic        start;
   logic [31:0] result, hi, lo;
   logic        zero, overflow, busy, done;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_hi, m_lo;
   logic [63:0] exp_md;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .start       (start),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Single-cycle reference: {overflow, result}
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] x, y, h, l);
      longint sx, sy, s;
      logic [31:0] r;
      logic        v;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = 32'd0;
      v  = 1'b0;
      case (op)
         4'h2: begin s = sx + sy; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h6: begin s = sx - sy; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'h3: r = x ^ y;
         4'hC: r = ~(x | y);
         4'h7: r = (sx < sy) ? 32'd1 : 32'd0;
         4'h8: r = (x < y) ? 32'd1 : 32'd0;
         4'hA: r = h;
         4'hB: r = l;
         default: r = 32'd0;
      endcase
      return {v, r};
   endfunction

   // Mul/div reference: {hi, lo}
   function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] x, y);
      longint      sx, sy, q, rm;
      logic [63:0] u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (op)
         4'h4: begin q = sx * sy; return q; end
         4'h5: begin u = {32'd0, x} * {32'd0, y}; return u; end
         4'hD: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            q = sx / sy; rm = sx % sy;
            return {rm[31:0], q[31:0]};
         end
         4'hE: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: return 64'd0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] x, y);
      alu_control = op;
      a           = x;
      b           = y;
      start       = 1'b1;
      exp_md      = ref_md(op, x, y);
      step();
      start = 1'b0;
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      chk("done_low_after_start", {63'd0, done}, 64'd0);
   endtask

   // Returns in the done cycle; noise scrambles operands, probes MFHI and pokes start
   task automatic wait_done(input string tag, input bit noise);
      int n = 0;
      while (!done && n < 60) begin
         if (noise) begin
            a = $urandom;
            b = $urandom;
            if (n == 10) begin
               alu_control = 4'b0101;
               start       = 1'b1;
            end else begin
               alu_control = 4'b1010;
               start       = 1'b0;
               #1;
               chk({tag, "_mfhi_busy"}, {32'd0, result}, {32'd0, m_hi});
            end
         end
         step();
         n++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 64'(n), 64'd33);
      chk({tag, "_busy_fell"}, {63'd0, busy}, 64'd0);
      chk({tag, "_hilo"}, {hi, lo}, exp_md);
      m_hi = exp_md[63:32];
      m_lo = exp_md[31:0];
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [31:0] x, y,
                         input logic [31:0] er, input logic ev, input logic ez);
      alu_control = op;
      a = x;
      b = y;
      #1;
      chk({tag, "_result"}, {32'd0, result}, {32'd0, er});
      chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, ev});
      chk({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
   endtask

   initial begin
      logic [32:0] r;
      logic [31:0] x, y;
      logic [3:0]  op;
      int          pulses;
      logic [3:0]  md_ops [4];
      md_ops = '{4'h4, 4'h5, 4'hD, 4'hE};

      reset_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_control = 4'h0;
      m_hi = '0; m_lo = '0;
      step(); step();
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      reset_n = 1'b1;
      step();

      single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
      single("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
      single("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
      single("sltu", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
      single("undef", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b1);
      single("mult_code", 4'b0100, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);

      // Directed mul/div chain, each next op launched in the done cycle
      launch(4'b0100, 32'hFFFF_FFFD, 32'd7);
      wait_done("mult", 1'b0);
      chk("mult_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      chk("mult_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
      launch(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu", 1'b0);
      chk("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      launch(4'b1101, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_noise", 1'b1);
      chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      launch(4'b1110, 32'd7, 32'd0);
      wait_done("divu_zero", 1'b0);
      chk("divu_zero_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
      launch(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_min", 1'b0);
      chk("div_min_const", {hi, lo}, 64'h0000_0000_8000_0000);
      step();
      chk("done_single_pulse", {63'd0, done}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);

      for (int i = 0; i < 16; i++) begin
         op = md_ops[$urandom_range(0, 3)];
         x  = $urandom;
         y  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 2) == 0) y = y & 32'hFF;
         launch(op, x, y);
         wait_done("rand_md", (i % 4) == 1);
      end

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 4))
            0: x = 32'h7FFF_FFFF;
            1: x = 32'h8000_0000;
            default: x = $urandom;
         endcase
         y = ($urandom_range(0, 3) == 0) ? x : 32'($urandom);
         alu_control = op;
         a = x;
         b = y;
         #1;
         r = ref_alu(op, x, y, m_hi, m_lo);
         chk("rand_result", {32'd0, result}, {32'd0, r[31:0]});
         chk("rand_ovf", {63'd0, overflow}, {63'd0, r[32]});
         chk("rand_zero", {63'd0, zero}, {63'd0, (r[31:0] == 32'd0)});
      end

      // Reset in the middle of an iteration
      launch(4'b0100, 32'd1234, 32'd5678);
      for (int i = 0; i < 10; i++) step();
      reset_n = 1'b0;
      step();
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      reset_n = 1'b1;
      m_hi = '0;
      m_lo = '0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done) pulses++;
      end
      chk("midrst_no_done", 64'(pulses), 64'd0);
      alu_control = 4'b1010;
      #1;
      chk("midrst_mfhi", {32'd0, result}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
